// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction prefetch stage: bus FSM encoding and address constants.
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] WORD_STRIDE      = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory bus: single outstanding request on req/gnt, in-order rvalid/rdata return.
interface instr_fetch_unit_if;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemGnt;
    logic        imemRvalid;
    logic [31:0] imemRdata;

    modport master (output imemReq, imemAddr, input imemGnt, imemRvalid, imemRdata);
    modport slave  (input imemReq, imemAddr, output imemGnt, imemRvalid, imemRdata);
endinterface

// File: rtl/instr_fetch_unit_fetch_queue.sv
// Circular prefetch FIFO of {addr, data} pairs with head and head+1 read ports for tag lookup.
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [31:0]             push_addr,
    input  logic [31:0]             push_data,
    input  logic                    pop,
    input  logic                    flush,
    output logic [$clog2(DEPTH):0]  count,
    output logic [31:0]             head_addr,
    output logic [31:0]             head_data,
    output logic [31:0]             sec_addr,
    output logic [31:0]             sec_data
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   addr_mem_q [DEPTH];
    logic [31:0]   addr_mem_d [DEPTH];
    logic [31:0]   data_mem_q [DEPTH];
    logic [31:0]   data_mem_d [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] sec_ptr;
    logic [AW:0]   count_q, count_d;
    logic          push_ok, pop_ok;

    assign push_ok = push && (count_q != (AW+1)'(DEPTH));
    assign pop_ok  = pop && (count_q != '0);
    assign sec_ptr = rd_ptr_q + AW'(1);

    always_comb begin
        addr_mem_d = addr_mem_q;
        data_mem_d = data_mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                addr_mem_d[wr_ptr_q] = push_addr;
                data_mem_d[wr_ptr_q] = push_data;
                wr_ptr_d             = wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry contents are don't-care after reset; count gates every use.
    always_ff @(posedge clk) begin
        addr_mem_q <= addr_mem_d;
        data_mem_q <= data_mem_d;
    end

    assign count     = count_q;
    assign head_addr = addr_mem_q[rd_ptr_q];
    assign head_data = data_mem_q[rd_ptr_q];
    assign sec_addr  = addr_mem_q[sec_ptr];
    assign sec_data  = data_mem_q[sec_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction prefetch stage: tag lookup against pcIn, redirect detection and the
// single-outstanding-request bus FSM.
//   state   | meaning
//   ST_IDLE | no request outstanding
//   ST_WAIT | one request outstanding, response will be queued
//   ST_DROP | one request outstanding, response will be discarded
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                pcIn,
    output logic [31:0]                instr,
    output logic                       ifValid,
    instr_fetch_unit_if.master         imem
);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_addr_q, fetch_addr_d;
    logic [31:0]  inflight_addr_q, inflight_addr_d;

    logic [CW-1:0] count;
    logic [31:0]   head_addr, head_data, sec_addr, sec_data;
    logic          has1, has2, head_hit, sec_hit, pending, redirect;
    logic          room, issue, grant, push;

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_addr (inflight_addr_q),
        .push_data (imem.imemRdata),
        .pop       (sec_hit),
        .flush     (redirect),
        .count     (count),
        .head_addr (head_addr),
        .head_data (head_data),
        .sec_addr  (sec_addr),
        .sec_data  (sec_data)
    );

    assign has1     = (count != '0);
    assign has2     = (count > CW'(1));
    assign head_hit = has1 && (head_addr == pcIn);
    assign sec_hit  = !head_hit && has2 && (sec_addr == pcIn);
    // Pending means the word is on its way; anything else is a redirect.
    assign pending  = !head_hit && !sec_hit &&
                      ((has1 && (pcIn == head_addr + WORD_STRIDE)) ||
                       (!has1 && (((state_q == ST_WAIT) && (pcIn == inflight_addr_q)) ||
                                  (pcIn == fetch_addr_q))));
    assign redirect = !head_hit && !sec_hit && !pending;

    assign room  = (int'(count) + int'(state_q != ST_IDLE)) < DEPTH;
    assign issue = ((state_q == ST_IDLE) || ((state_q == ST_WAIT) && imem.imemRvalid)) &&
                   !redirect && room;

    assign imem.imemReq  = issue && rst;
    assign imem.imemAddr = word_align(fetch_addr_q);
    assign grant         = imem.imemReq && imem.imemGnt;

    assign ifValid = (head_hit || sec_hit) && rst;
    assign instr   = !rst    ? 32'h0 :
                     head_hit ? head_data :
                     sec_hit  ? sec_data  : 32'h0;

    always_comb begin
        state_d         = state_q;
        fetch_addr_d    = fetch_addr_q;
        inflight_addr_d = inflight_addr_q;
        push            = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem.imemRvalid) begin
                    push    = !redirect;
                    state_d = grant ? ST_WAIT : ST_IDLE;
                end else if (redirect) begin
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                if (imem.imemRvalid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (grant) begin
            fetch_addr_d    = fetch_addr_q + WORD_STRIDE;
            inflight_addr_d = fetch_addr_q;
        end
        if (redirect) begin
            fetch_addr_d = pcIn;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            fetch_addr_q    <= RESET_PC;
            inflight_addr_q <= RESET_PC;
        end else begin
            state_q         <= state_d;
            fetch_addr_q    <= fetch_addr_d;
            inflight_addr_q <= inflight_addr_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: memory model returns word == address after a configurable latency.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pcIn;
    logic [31:0] instr;
    logic        ifValid;

    always #5 clk = ~clk;

    instr_fetch_unit_if imem_bus ();

    instr_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk     (clk),
        .rst     (rst),
        .pcIn    (pcIn),
        .instr   (instr),
        .ifValid (ifValid),
        .imem    (imem_bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] exp_instr;
        int          max_wait;
        logic        chk_req;
        logic [31:0] exp_req;
    } vec_t;

    int          n_vec = 0;
    int          n_err = 0;
    int          lat   = 1;
    logic        pend_v = 1'b0;
    logic [31:0] pend_addr;
    int          pend_cnt;
    logic [31:0] exp_q [$];
    vec_t        vecs [10];
    logic        seen_req;
    logic [31:0] first_req;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Advance one cycle; the memory model answers each grant after lat cycles.
    task automatic tick();
        logic        granted;
        logic [31:0] gaddr;
        granted = imem_bus.imemReq && imem_bus.imemGnt;
        gaddr   = imem_bus.imemAddr;
        @(posedge clk);
        #1;
        imem_bus.imemRvalid = 1'b0;
        if (granted) begin
            pend_v    = 1'b1;
            pend_addr = gaddr;
            pend_cnt  = lat;
        end
        if (pend_v) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                imem_bus.imemRvalid = 1'b1;
                imem_bus.imemRdata  = pend_addr;
                pend_v              = 1'b0;
            end
        end
    endtask

    task automatic reset_dut(input logic [31:0] pc, input int l);
        rst                 = 1'b0;
        pcIn                = pc;
        lat                 = l;
        pend_v              = 1'b0;
        imem_bus.imemGnt    = 1'b1;
        imem_bus.imemRvalid = 1'b0;
        imem_bus.imemRdata  = 32'h0;
        tick();
        #1;
        check("reset imemReq", 32'(imem_bus.imemReq), 32'd0);
        check("reset ifValid", 32'(ifValid), 32'd0);
        check("reset instr", instr, 32'h0);
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic wait_valid(input string name, input int max_wait,
                              output logic sr, output logic [31:0] fr);
        logic        got;
        logic [31:0] exp;
        got = 1'b0;
        sr  = 1'b0;
        fr  = 32'h0;
        for (int w = 0; w <= max_wait; w++) begin
            if (w > 0) tick();
            #1;
            if (!sr && imem_bus.imemReq) begin
                sr = 1'b1;
                fr = imem_bus.imemAddr;
            end
            if (ifValid) begin
                got = 1'b1;
                break;
            end
        end
        exp = exp_q.pop_front();
        if (got) check(name, instr, exp);
        else     check({name, " ifValid"}, 32'(ifValid), 32'd1);
    endtask

    task automatic drive_pc(input logic [31:0] pc, input logic [31:0] exp);
        tick();
        pcIn = pc;
        exp_q.push_back(exp);
    endtask

    initial begin
        vecs = '{
            '{32'h0000_0004, 32'h0000_0004, 0, 1'b0, 32'h0},
            '{32'h0000_0008, 32'h0000_0008, 0, 1'b0, 32'h0},
            '{32'h0000_000C, 32'h0000_000C, 0, 1'b0, 32'h0},
            '{32'h0000_0010, 32'h0000_0010, 0, 1'b0, 32'h0},
            '{32'h0000_0200, 32'h0000_0200, 6, 1'b1, 32'h0000_0200},
            '{32'h0000_0204, 32'h0000_0204, 0, 1'b0, 32'h0},
            '{32'h0000_0208, 32'h0000_0208, 0, 1'b0, 32'h0},
            '{32'h0000_020C, 32'h0000_020C, 0, 1'b0, 32'h0},
            '{32'h0000_0000, 32'h0000_0000, 6, 1'b1, 32'h0000_0000},
            '{32'h0000_0004, 32'h0000_0004, 0, 1'b0, 32'h0}
        };

        // Startup: requests 0,4,8 back to back, first hit at cycle 2.
        reset_dut(32'h0, 1);
        #1;
        check("c0 imemReq", 32'(imem_bus.imemReq), 32'd1);
        check("c0 imemAddr", imem_bus.imemAddr, 32'h0);
        check("c0 ifValid", 32'(ifValid), 32'd0);
        check("c0 instr", instr, 32'h0);
        tick(); #1;
        check("c1 imemAddr", imem_bus.imemAddr, 32'h4);
        check("c1 ifValid", 32'(ifValid), 32'd0);
        tick(); #1;
        check("c2 imemAddr", imem_bus.imemAddr, 32'h8);
        check("c2 ifValid", 32'(ifValid), 32'd1);
        check("c2 instr", instr, 32'h0);

        for (int i = 0; i < 10; i++) begin
            drive_pc(vecs[i].pc, vecs[i].exp_instr);
            wait_valid($sformatf("vec%0d instr", i), vecs[i].max_wait, seen_req, first_req);
            if (vecs[i].chk_req) begin
                if (seen_req) check($sformatf("vec%0d redirect addr", i), first_req, vecs[i].exp_req);
                else          check($sformatf("vec%0d redirect req", i), 32'(imem_bus.imemReq), 32'd1);
            end
        end

        // Grant withheld on the 0x8 request, then core stalls at 0x4 until the queue fills.
        reset_dut(32'h0, 1);
        #1;
        tick(); #1;
        for (int i = 0; i < 3; i++) begin
            tick();
            imem_bus.imemGnt = 1'b0;
            #1;
            check($sformatf("stall%0d imemReq", i), 32'(imem_bus.imemReq), 32'd1);
            check($sformatf("stall%0d imemAddr", i), imem_bus.imemAddr, 32'h8);
        end
        tick();
        imem_bus.imemGnt = 1'b1;
        #1;
        check("stall release imemAddr", imem_bus.imemAddr, 32'h8);
        drive_pc(32'h4, 32'h4);
        wait_valid("stall pc4", 0, seen_req, first_req);
        repeat (7) begin
            tick(); #1;
        end
        check("full imemReq", 32'(imem_bus.imemReq), 32'd0);
        check("full ifValid", 32'(ifValid), 32'd1);
        check("full instr", instr, 32'h4);
        drive_pc(32'h8, 32'h8);
        wait_valid("full pc8", 0, seen_req, first_req);
        drive_pc(32'hC, 32'hC);
        wait_valid("full pcC", 0, seen_req, first_req);
        drive_pc(32'h10, 32'h10);
        wait_valid("full pc10", 0, seen_req, first_req);

        // Latency 2: redirect while a request is outstanding forces a drop.
        reset_dut(32'h0, 2);
        #1;
        tick(); #1;
        check("lat2 wait imemReq", 32'(imem_bus.imemReq), 32'd0);
        tick(); #1;
        check("lat2 rvalid imemAddr", imem_bus.imemAddr, 32'h4);
        drive_pc(32'h200, 32'h200);
        #1;
        check("drop redirect imemReq", 32'(imem_bus.imemReq), 32'd0);
        check("drop redirect ifValid", 32'(ifValid), 32'd0);
        tick(); #1;
        check("drop imemReq", 32'(imem_bus.imemReq), 32'd0);
        check("drop ifValid", 32'(ifValid), 32'd0);
        tick(); #1;
        check("after drop imemReq", 32'(imem_bus.imemReq), 32'd1);
        check("after drop imemAddr", imem_bus.imemAddr, 32'h200);
        wait_valid("after drop instr", 6, seen_req, first_req);

        // Misaligned target: request goes out word-aligned.
        tick();
        pcIn = 32'h302;
        #1;
        check("misaligned redirect imemReq", 32'(imem_bus.imemReq), 32'd0);
        seen_req = 1'b0;
        for (int w = 0; w < 6 && !seen_req; w++) begin
            tick(); #1;
            if (imem_bus.imemReq) begin
                seen_req  = 1'b1;
                first_req = imem_bus.imemAddr;
            end
        end
        if (seen_req) check("misaligned imemAddr", first_req, 32'h300);
        else          check("misaligned imemReq", 32'(imem_bus.imemReq), 32'd1);

        // Reset while a response is arriving: it must not be queued.
        reset_dut(32'h0, 1);
        #1;
        tick();
        rst = 1'b0;
        #1;
        check("midreset imemReq", 32'(imem_bus.imemReq), 32'd0);
        tick();
        rst = 1'b1;
        #1;
        check("post reset ifValid", 32'(ifValid), 32'd0);
        check("post reset instr", instr, 32'h0);
        check("post reset imemAddr", imem_bus.imemAddr, 32'h0);
        check("post reset imemReq", 32'(imem_bus.imemReq), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
